// File: rtl/imem_fetch_unit_pkg.sv
// Shared constants and FSM encoding for the instruction-memory fetch unit.
package imem_fetch_unit_pkg;

  localparam int unsigned ISIZE_DEF     = 16;
  localparam int unsigned MEM_SPACE_DEF = 8;
  localparam logic [15:0] NOP_WORD_DEF  = 16'h0000;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/imem_ram.sv
// Synchronous RAM with a registered read port; no reset on contents or read data.
module imem_ram #(
  parameter int unsigned ISIZE     = 16,
  parameter int unsigned MEM_SPACE = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [MEM_SPACE-1:0] waddr,
  input  logic [ISIZE-1:0]     wdata,
  input  logic [MEM_SPACE-1:0] raddr,
  output logic [ISIZE-1:0]     rdata
);

  logic [ISIZE-1:0] mem [2**MEM_SPACE];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_fetch_unit.sv
// Runtime-loaded instruction memory: LOAD words, NOP-fill the tail, then serve
// one registered fetch per cycle with hold replay, flush and out-of-range fault.
module imem_fetch_unit
  import imem_fetch_unit_pkg::*;
#(
  parameter int unsigned       ISIZE     = ISIZE_DEF,
  parameter int unsigned       MEM_SPACE = MEM_SPACE_DEF,
  parameter logic [ISIZE-1:0]  NOP_WORD  = ISIZE'(NOP_WORD_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  input  logic [ISIZE-1:0]     load_data,
  input  logic                 load_last,
  output logic                 load_ready,
  input  logic [MEM_SPACE:0]   address,
  input  logic                 hold,
  input  logic                 flush,
  output logic [ISIZE-1:0]     data_out,
  output logic                 fetch_valid,
  output logic                 fault,
  output logic [MEM_SPACE:0]   load_count
);

  localparam int unsigned    AW    = MEM_SPACE + 1;
  localparam logic [AW-1:0]  DEPTH = AW'(2**MEM_SPACE);
  localparam logic [AW-1:0]  LAST  = AW'(2**MEM_SPACE - 1);

  state_t                state_q, state_d;
  logic [AW-1:0]         wr_ptr;
  logic                  ram_we;
  logic [ISIZE-1:0]      ram_wdata;
  logic                  ptr_inc;
  logic                  load_fire;
  logic                  nop_sel;
  logic [MEM_SPACE-1:0]  last_addr;
  logic [MEM_SPACE-1:0]  raddr;
  logic [ISIZE-1:0]      rdata;

  assign load_fire = load_valid && load_ready;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_LOAD;
    else      state_q <= state_d;
  end

  // Word depth-1 is the last writable slot; CLEAR exits on the edge that fills it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:  if (load_fire && (load_last || wr_ptr == LAST)) state_d = ST_CLEAR;
      ST_CLEAR: if (wr_ptr >= LAST) state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    ram_we     = 1'b0;
    ram_wdata  = NOP_WORD;
    ptr_inc    = 1'b0;
    case (state_q)
      ST_LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          ram_we    = 1'b1;
          ram_wdata = load_data;
          ptr_inc   = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (wr_ptr != DEPTH) begin
          ram_we  = 1'b1;
          ptr_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Fetch control; nop_sel forces NOP_WORD over the RAM read register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr      <= '0;
      load_count  <= '0;
      nop_sel     <= 1'b1;
      fetch_valid <= 1'b0;
      fault       <= 1'b0;
      last_addr   <= '0;
    end else begin
      if (ptr_inc)   wr_ptr     <= wr_ptr + AW'(1);
      if (load_fire) load_count <= load_count + AW'(1);
      if (state_q == ST_RUN) begin
        if (flush) begin
          nop_sel     <= 1'b1;
          fetch_valid <= 1'b0;
        end else if (hold) begin
          nop_sel     <= nop_sel;
        end else if (address[MEM_SPACE]) begin
          nop_sel     <= 1'b1;
          fetch_valid <= 1'b0;
          fault       <= 1'b1;
        end else begin
          nop_sel     <= 1'b0;
          fetch_valid <= 1'b1;
          last_addr   <= address[MEM_SPACE-1:0];
        end
      end else begin
        nop_sel     <= 1'b1;
        fetch_valid <= 1'b0;
      end
    end
  end

  // Memory is read-only in RUN, so re-reading the last address replays the held word.
  assign raddr    = (hold && !flush) ? last_addr : address[MEM_SPACE-1:0];
  assign data_out = nop_sel ? NOP_WORD : rdata;

  imem_ram #(
    .ISIZE     (ISIZE),
    .MEM_SPACE (MEM_SPACE)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr[MEM_SPACE-1:0]),
    .wdata (ram_wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed bench for imem_fetch_unit: load, clear, fetch, hold, flush, fault, full load, reset.
module tb_imem_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic [8:0]  address;
  logic        hold;
  logic        flush;
  logic [15:0] data_out;
  logic        fetch_valid;
  logic        fault;
  logic [8:0]  load_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt;

  imem_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .address     (address),
    .hold        (hold),
    .flush       (flush),
    .data_out    (data_out),
    .fetch_valid (fetch_valid),
    .fault       (fault),
    .load_count  (load_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [15:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic fetch(input logic [8:0] a);
    address = a;
    step();
  endtask

  // Counts edges until the first valid fetch of address 0.
  task automatic wait_run(output int n);
    n = 0;
    address = 9'd0;
    do begin
      step();
      n++;
    end while (!fetch_valid && n < 400);
  endtask

  initial begin
    rst = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    address = '0; hold = 1'b0; flush = 1'b0;
    step(); step();
    check("rst_data", 32'(data_out), 32'h0000);
    check("rst_fv", 32'(fetch_valid), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_lcnt", 32'(load_count), 0);
    check("rst_ready", 32'(load_ready), 1);
    rst = 1'b1;

    // Three words then NOP fill of 253 slots
    load_word(16'h1111, 1'b0);
    load_word(16'h2222, 1'b0);
    load_word(16'h3333, 1'b1);
    check("lcnt3", 32'(load_count), 3);
    check("ready_clear", 32'(load_ready), 0);
    check("clear_data", 32'(data_out), 32'h0000);
    wait_run(cnt);
    check("clear_len", 32'(cnt), 254);
    check("f0", 32'(data_out), 32'h1111);
    fetch(9'd1); check("f1", 32'(data_out), 32'h2222);
    fetch(9'd2); check("f2", 32'(data_out), 32'h3333);
    fetch(9'd3); check("f3", 32'(data_out), 32'h0000);
    check("f3_fv", 32'(fetch_valid), 1);

    // Hold replays the previous word
    fetch(9'd1); check("h_pre", 32'(data_out), 32'h2222);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch(9'd2);
      check("hold_data", 32'(data_out), 32'h2222);
      check("hold_fv", 32'(fetch_valid), 1);
    end
    hold = 1'b0;
    fetch(9'd2); check("h_post", 32'(data_out), 32'h3333);

    // Flush wins over hold
    hold = 1'b1; flush = 1'b1;
    fetch(9'd0);
    check("flush_data", 32'(data_out), 32'h0000);
    check("flush_fv", 32'(fetch_valid), 0);
    hold = 1'b0; flush = 1'b0;
    fetch(9'd0); check("post_flush", 32'(data_out), 32'h1111);

    // Out-of-range fetch sets sticky fault
    fetch(9'h100);
    check("oor_data", 32'(data_out), 32'h0000);
    check("oor_fv", 32'(fetch_valid), 0);
    check("oor_fault", 32'(fault), 1);
    fetch(9'd0);
    check("sticky_data", 32'(data_out), 32'h1111);
    check("sticky_fault", 32'(fault), 1);

    // Full 256-word load without load_last
    rst = 1'b0; step(); rst = 1'b1;
    check("rst2_fault", 32'(fault), 0);
    for (int i = 0; i < 256; i++) load_word(16'hC000 + 16'(i), 1'b0);
    check("full_lcnt", 32'(load_count), 256);
    check("full_ready", 32'(load_ready), 0);
    load_valid = 1'b1; load_data = 16'hBEEF; address = 9'd255;
    step();
    load_valid = 1'b0;
    check("extra_lcnt", 32'(load_count), 256);
    check("extra_fv", 32'(fetch_valid), 0);
    fetch(9'd255);
    check("full_255", 32'(data_out), 32'hC0FF);
    check("full_255_fv", 32'(fetch_valid), 1);
    fetch(9'd0); check("full_0", 32'(data_out), 32'hC000);

    // Reset in the middle of LOAD restarts at address 0
    rst = 1'b0; step(); rst = 1'b1;
    load_word(16'h1234, 1'b0);
    load_word(16'h5678, 1'b0);
    rst = 1'b0; step(); rst = 1'b1;
    check("mid_lcnt", 32'(load_count), 0);
    check("mid_ready", 32'(load_ready), 1);
    load_word(16'hA5A5, 1'b1);
    check("reload_lcnt", 32'(load_count), 1);
    wait_run(cnt);
    check("reload_clear_len", 32'(cnt), 256);
    check("reload_0", 32'(data_out), 32'hA5A5);
    fetch(9'd1);
    check("reload_1", 32'(data_out), 32'h0000);
    check("reload_1_fv", 32'(fetch_valid), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
